// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receive-side byte packer.
// Contents: word/byte widths, default word FIFO depth and the pairing FSM state type.
package spart_pkg;

  localparam int SPART_WORD_W    = 16;
  localparam int SPART_BYTE_W    = 8;
  localparam int SPART_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE_HI = 1'b0,
    WAIT_LO = 1'b1
  } pair_state_t;

endpackage

// File: rtl/spart_word_fifo.sv
// Synchronous word FIFO for packed SPART receive words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write wdata (accepted when not full, or when full with a same-cycle pop)
//   pop         remove head word (ignored when empty)
//   flush       synchronous clear; wins over push and pop
//   wdata       word to write
//   rdata       head word, all-zero when empty
//   count       number of buffered words
//   full/empty  occupancy flags derived from count
module spart_word_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = SPART_DEPTH_DEF,
  parameter int W     = SPART_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // When full, a same-cycle pop frees the slot the write pointer is sitting on,
  // so the write lands in the slot being vacated.
  assign pop_ok  = pop  & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spart_rx_packer.sv
// SPART receive packer: pairs consecutive received bytes into 16-bit words
// (high byte first by default, matching the transmit order) and buffers them
// for the WB-stage source mux "spart" input.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rx_byte     byte from the SPART receiver, qualified by rx_valid
//   rx_valid    single-cycle byte strobe
//   rx_err      framing/parity error strobe; discards current and held byte
//   rd_en       processor pops the head word
//   flush       synchronous clear of FIFO and any held byte
//   clr_ovf     clears the sticky overflow flag (a same-cycle overflow wins)
//   rd_data     head word, 16'h0000 when empty
//   rd_valid    FIFO non-empty
//   half        one byte held, awaiting its pair
//   overflow    sticky: a completed word was dropped on a full FIFO
//   count       buffered word count
//
// state   | meaning
// IDLE_HI | no byte held; next good byte is loaded into the hold register
// WAIT_LO | one byte held; next good byte completes and pushes a word
module spart_rx_packer
  import spart_pkg::*;
#(
  parameter int DEPTH    = SPART_DEPTH_DEF,
  parameter int HI_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SPART_BYTE_W-1:0] rx_byte,
  input  logic                    rx_valid,
  input  logic                    rx_err,
  input  logic                    rd_en,
  input  logic                    flush,
  input  logic                    clr_ovf,
  output logic [SPART_WORD_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    half,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  count
);

  pair_state_t             state;
  pair_state_t             state_nxt;
  logic [SPART_BYTE_W-1:0] hold;
  logic                    hold_load;
  logic                    push_req;
  logic [SPART_WORD_W-1:0] word;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush and byte errors both abandon any half-built word; bytes arriving in
  // those cycles are discarded.
  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    push_req  = 1'b0;
    if (flush || rx_err) begin
      state_nxt = IDLE_HI;
    end else if (rx_valid) begin
      case (state)
        IDLE_HI: begin
          hold_load = 1'b1;
          state_nxt = WAIT_LO;
        end
        WAIT_LO: begin
          push_req  = 1'b1;
          state_nxt = IDLE_HI;
        end
        default: state_nxt = IDLE_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (flush || rx_err) begin
      hold <= '0;
    end else if (hold_load) begin
      hold <= rx_byte;
    end
  end

  assign word = (HI_FIRST != 0) ? {hold, rx_byte} : {rx_byte, hold};

  // A completed word is lost only when the FIFO is full and no pop frees a slot
  // this cycle; push_req is already suppressed during flush.
  assign drop = push_req & fifo_full & ~(rd_en & ~fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  spart_word_fifo #(
    .DEPTH (DEPTH),
    .W     (SPART_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (rd_en),
    .flush (flush),
    .wdata (word),
    .rdata (rd_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign half     = (state == WAIT_LO);

endmodule
